// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
package mips_mem_pkg;

    // Width of the wait-state down-counter; covers wait-state counts 0..15.
    localparam int CNT_WIDTH = 4;

    // Access sequencing: idle, inserting wait states, one-cycle response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mips_data_mem_array.sv
// Word-addressed storage: one synchronous write port and one registered read port.
// Only the read register is reset; the stored words keep their contents.
module mips_data_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Storage write port; no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Next read-register value: load a word, force zero, or hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem[addr];
        end
    end

    // Read output register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mips_data_mem_responder.sv
// MIPS data-memory responder: accepts one access in IDLE, inserts a fixed
// number of wait states, then answers with a one-cycle mem_ready strobe.
module mips_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  mem_req,
    input  logic                  DATA_MEM_WR_EN,
    input  logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  mem_ready,
    output logic                  addr_err,
    output logic                  busy
);

    localparam int                   IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int                   WIDX_W    = ADDR_WIDTH - 2;
    localparam logic [WIDX_W-1:0]    DEPTH_LIM = WIDX_W'(MEM_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT  = CNT_WIDTH'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wr_q, wr_d;
    logic                    mem_ready_q, mem_ready_d;
    logic                    addr_err_q, addr_err_d;
    logic                    busy_q, busy_d;

    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_data;
    logic                    acc_wr;
    logic                    acc_ok;
    logic                    go_resp;
    logic                    mem_wr_en;
    logic                    mem_rd_en;
    logic                    mem_rd_clr;

    // Access being completed: live inputs when leaving IDLE directly (zero
    // wait states), otherwise the values latched at acceptance.
    always_comb begin
        acc_addr = addr_q;
        acc_data = wdata_q;
        acc_wr   = wr_q;
        if (state_q == IDLE) begin
            acc_addr = input_addr;
            acc_data = write_data;
            acc_wr   = DATA_MEM_WR_EN;
        end
        acc_ok = (acc_addr[1:0] == 2'b00) && (acc_addr[ADDR_WIDTH-1:2] < DEPTH_LIM);
    end

    // Next-state, counter and request latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    addr_d  = input_addr;
                    wdata_d = write_data;
                    wr_d    = DATA_MEM_WR_EN;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory commands and registered outputs, all keyed to the edge entering RESP.
    always_comb begin
        go_resp     = RST_N && (state_d == RESP) && (state_q != RESP);
        mem_wr_en   = go_resp && acc_wr && acc_ok;
        mem_rd_en   = go_resp && !acc_wr && acc_ok;
        mem_rd_clr  = go_resp && (acc_wr || !acc_ok);
        mem_ready_d = (state_d == RESP);
        addr_err_d  = go_resp && !acc_ok;
        busy_d      = (state_d != IDLE);
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            mem_ready_q <= 1'b0;
            addr_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            mem_ready_q <= mem_ready_d;
            addr_err_q  <= addr_err_d;
            busy_q      <= busy_d;
        end
    end

    mips_data_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr_en   (mem_wr_en),
        .rd_en   (mem_rd_en),
        .rd_clr  (mem_rd_clr),
        .addr    (acc_addr[IDX_W+1:2]),
        .wr_data (acc_data),
        .rd_data (read_data)
    );

    assign mem_ready = mem_ready_q;
    assign addr_err  = addr_err_q;
    assign busy      = busy_q;

endmodule
